instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, 4: prefetch buffer entries; SHALL be a power of two, 2..16.
REQ-003 Port clk  in  1: single clock; all state updates on rising edge.
REQ-004 Port reset  in  1: asynchronous, active-high reset.
REQ-005 Port fetch_en  in  1: fetch enable; 0 stops new memory requests.
REQ-006 Port imem_req  out  1: instruction memory request.
REQ-007 Port imem_addr  out  32: word-aligned fetch address.
REQ-008 Port imem_ack  in  1: memory accepts request; rdata valid the same cycle.
REQ-009 Port imem_rdata  in  32: fetched instruction word.
REQ-010 Port redirect_valid  in  1: one-cycle PC redirect (branch/jump).
REQ-011 Port redirect_pc  in  32: redirect target.
REQ-012 Port instruction  out  32: instruction word to the processor stage.
REQ-013 Port instr_pc  out  32: address of the instruction.
REQ-014 Port instr_valid  out  1: instruction/instr_pc valid.
REQ-015 Port instr_ready  in  1: processor consumes the head entry.

Function
REQ-016 A memory transfer SHALL complete on a clock edge where imem_req and imem_ack are both 1; the word SHALL be pushed with its address into the FIFO and the PC SHALL advance by 4, wrapping 32'hFFFF_FFFC to 0.
REQ-017 imem_req and imem_addr SHALL remain stable until imem_ack, unless redirect_valid or reset occurs.
REQ-018 FSM states: IDLE (fetch_en=0), FETCH (imem_req=1), FULL (FIFO has no free slot, imem_req=0).
REQ-019 Transitions: IDLE->FETCH when fetch_en=1; FETCH->FULL when a push fills the last slot; FULL->FETCH on a pop; FETCH->IDLE when fetch_en=0 and no request is pending with ack; any->FETCH on redirect when fetch_en=1.
REQ-020 The head entry SHALL pop on an edge with instr_valid=1 and instr_ready=1; instr_valid=0 when the FIFO is empty.
REQ-021 Simultaneous push and pop on a full FIFO SHALL NOT be permitted; imem_req SHALL already be 0 in FULL. Simultaneous push and pop on a non-full FIFO SHALL keep the count unchanged.
REQ-022 Latency: a word acked in cycle N SHALL appear at the outputs with instr_valid=1 in cycle N+1 when the FIFO was empty.
REQ-023 redirect_valid SHALL have top priority: the FIFO is flushed, a same-cycle ack's data is dropped, and the PC is loaded with {redirect_pc[31:2],2'b00}. The outputs show instr_valid=0 in the next cycle, and imem_addr equals the target in the next cycle.
REQ-024 A pop in the redirect cycle SHALL be honoured by the consumer and SHALL be irrelevant to FIFO state after the flush.

Reset
REQ-025 While reset=1, the block SHALL hold: imem_req=0, imem_addr=RESET_PC, instruction=0, instr_pc=0, instr_valid=0, FIFO empty, state IDLE.
REQ-026 Reset asserted mid-request SHALL abandon the request immediately; an ack in the same cycle SHALL be ignored.

Configuration
REQ-027 With IFU_STALL_COUNT_EN defined, the block SHALL add output stall_cycles[31:0]. The counter SHALL reset to 0, increment on every cycle where imem_req=1 and imem_ack=0, and saturate at 32'hFFFF_FFFF.
REQ-028 Without IFU_STALL_COUNT_EN, the port and counter SHALL be absent, with identical remaining behaviour.

Structure
REQ-029 Package ifu_pkg SHALL hold ADDR_W=32, INSTR_W=32, the FSM state typedef, and the PC increment constant 4.
REQ-030 The FIFO SHALL be a sub-module ifu_fifo (parameterised depth, entries of {pc, instruction}, push/pop/flush/full/empty/count).

Verification
REQ-031 Reset then fetch_en=1 with imem_ack tied 1 -> addresses 0,4,8,...; instr_valid rises one cycle after the first ack with instr_pc=0.
REQ-032 instr_ready=0 with acks always 1 -> exactly 4 pushes, then FULL with imem_req=0; one pop -> imem_req=1 next cycle at address 16.
REQ-033 Ack delayed 3 cycles -> imem_addr held constant; stall_cycles=3 when IFU_STALL_COUNT_EN is defined.
REQ-034 redirect_pc=32'h0000_0103 with ack in the same cycle -> data dropped, instr_valid=0 next cycle, next imem_addr=32'h0000_0100.
REQ-035 Reset asserted mid-stream with 2 entries buffered -> all outputs at reset values immediately; fetch restarts at RESET_PC.
REQ-036 PC at 32'hFFFF_FFFC acked -> next imem_addr=0.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared widths, FSM state encoding and prefetch-entry payload for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [ADDR_W-1:0] PC_INC        = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_ALIGN_MASK = ~ADDR_W'(3);

    typedef logic [1:0] ifu_state_t;

    localparam ifu_state_t ST_IDLE  = 2'd0;
    localparam ifu_state_t ST_FETCH = 2'd1;
    localparam ifu_state_t ST_FULL  = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_if.sv
// Fetch-unit bus: memory request channel, redirect input and processor-side instruction stream.
// Carries stall_cycles only when IFU_STALL_COUNT_EN is defined.
interface ifu_if;
    import ifu_pkg::*;

    logic               fetch_en;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;
`ifdef IFU_STALL_COUNT_EN
    logic [31:0]        stall_cycles;
`endif

    // Environment side: memory, branch unit and decode stage
    modport master (
`ifdef IFU_STALL_COUNT_EN
        input  stall_cycles,
`endif
        output fetch_en, imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready,
        input  imem_req, imem_addr, instruction, instr_pc, instr_valid
    );

    modport slave (
`ifdef IFU_STALL_COUNT_EN
        output stall_cycles,
`endif
        input  fetch_en, imem_ack, imem_rdata, redirect_valid, redirect_pc, instr_ready,
        output imem_req, imem_addr, instruction, instr_pc, instr_valid
    );

endinterface

// File: rtl/ifu_fifo.sv
// Prefetch buffer of {pc, instruction} entries; power-of-two depth, flush clears all entries.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  ifu_entry_t       i_wdata,
    output ifu_entry_t       o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    ifu_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_wr = i_push && !o_full;
    assign w_rd = i_pop && !o_empty;

    // Storage is cleared on reset so the head reads as zero until the first push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= PTR_W'(r_wr_ptr + 1'b1);
            end
            if (w_rd) r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
            if (w_wr && !w_rd)      r_count <= CNT_W'(r_count + 1'b1);
            else if (!w_wr && w_rd) r_count <= CNT_W'(r_count - 1'b1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC fetch into a prefetch FIFO with redirect flush.
// Define IFU_STALL_COUNT_EN to add the saturating stall_cycles counter.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    ifu_if.slave io_bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    ifu_state_t       r_state;
    ifu_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic             r_imem_req;
    logic             w_push;
    logic             w_pop;
    logic             w_fill;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    ifu_entry_t       w_head;
    ifu_entry_t       w_wdata;

    // Redirect kills both the same-cycle push and the pop from FIFO's point of view
    assign w_push  = r_imem_req && io_bus.imem_ack && !io_bus.redirect_valid;
    assign w_pop   = io_bus.instr_valid && io_bus.instr_ready && !io_bus.redirect_valid;
    assign w_fill  = w_push && !w_pop && (w_count == CNT_W'(FIFO_DEPTH - 1));
    assign w_wdata = '{pc: r_pc, instr: io_bus.imem_rdata};

    ifu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (io_bus.redirect_valid),
        .i_wdata (w_wdata),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Next state and next PC
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (w_push) w_pc_nxt = ADDR_W'(r_pc + PC_INC);
        case (r_state)
            ST_IDLE:  if (io_bus.fetch_en) w_state_nxt = w_full ? ST_FULL : ST_FETCH;
            ST_FETCH: begin
                // An outstanding request is held until acked, even if fetch_en drops
                if (w_fill)                         w_state_nxt = ST_FULL;
                else if (w_push && !io_bus.fetch_en) w_state_nxt = ST_IDLE;
            end
            ST_FULL:  if (w_pop) w_state_nxt = io_bus.fetch_en ? ST_FETCH : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (io_bus.redirect_valid) begin
            w_pc_nxt    = io_bus.redirect_pc & PC_ALIGN_MASK;
            w_state_nxt = io_bus.fetch_en ? ST_FETCH : ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_imem_req <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_imem_req <= (w_state_nxt == ST_FETCH);
        end
    end

    assign io_bus.imem_req    = r_imem_req;
    assign io_bus.imem_addr   = r_pc;
    assign io_bus.instruction = w_head.instr;
    assign io_bus.instr_pc    = w_head.pc;
    assign io_bus.instr_valid = !w_empty;

`ifdef IFU_STALL_COUNT_EN
    logic [31:0] r_stall_cycles;

    // Cycles spent waiting on memory; sticks at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (r_imem_req && !io_bus.imem_ack && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign io_bus.stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic
// against a queue-based model of the fetch stream.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic clk;
    logic reset;
    ifu_if bus ();

    instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_xfer   = 0;
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_stall;

    task automatic drive_idle();
        bus.fetch_en = 0; bus.imem_ack = 0; bus.imem_rdata = '0;
        bus.redirect_valid = 0; bus.redirect_pc = '0; bus.instr_ready = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mq.delete(); m_pc = RESET_PC; m_stall = 0; n_xfer = 0;
    endtask

    // Advance one clock and update the model from what happened at that edge
    task automatic tick();
        logic xfer, pop, redir;
        logic [31:0] rd, tgt;
        xfer  = bus.imem_req && bus.imem_ack;
        pop   = bus.instr_valid && bus.instr_ready;
        redir = bus.redirect_valid;
        rd    = bus.imem_rdata;
        tgt   = bus.redirect_pc;
        if (bus.imem_req && !bus.imem_ack && m_stall != 32'hFFFF_FFFF) m_stall++;
        @(posedge clk); #1;
        if (redir) begin
            mq.delete();
            m_pc = {tgt[31:2], 2'b00};
        end else begin
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (xfer) begin mq.push_back({m_pc, rd}); m_pc = m_pc + 32'd4; n_xfer++; end
        end
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", bus.imem_req); end
        n_checks++; if (bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL rst_addr: got %h expected %h", bus.imem_addr, RESET_PC); end
        n_checks++; if (bus.instruction !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h expected 0", bus.instruction); end
        n_checks++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_ipc: got %h expected 0", bus.instr_pc); end
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus.instr_valid); end
        reset = 1'b0;
        mq.delete(); m_pc = RESET_PC; m_stall = 0; n_xfer = 0;
    endtask

    task automatic test_stream();
        do_reset();
        bus.fetch_en = 1; bus.imem_ack = 1; bus.instr_ready = 1;
        for (int c = 0; c < 12; c++) begin
            n_checks++; if (bus.imem_addr !== m_pc) begin n_fail++; $display("FAIL stream_addr c%0d: got %h expected %h", c, bus.imem_addr, m_pc); end
            n_checks++; if (bus.instr_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL stream_valid c%0d: got %b expected %b", c, bus.instr_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_checks++; if ({bus.instr_pc, bus.instruction} !== mq[0]) begin n_fail++; $display("FAIL stream_head c%0d: got %h expected %h", c, {bus.instr_pc, bus.instruction}, mq[0]); end
            end
            bus.imem_rdata = $urandom;
            tick();
        end
        n_checks++; if (n_xfer < 10) begin n_fail++; $display("FAIL stream_xfers: got %0d expected >=10", n_xfer); end
    endtask

    task automatic test_full();
        do_reset();
        bus.fetch_en = 1; bus.imem_ack = 1; bus.instr_ready = 0;
        for (int c = 0; c < 8; c++) begin bus.imem_rdata = $urandom; tick(); end
        n_checks++; if (n_xfer !== 4) begin n_fail++; $display("FAIL full_pushes: got %0d expected 4", n_xfer); end
        n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req: got %b expected 0", bus.imem_req); end
        n_checks++; if (bus.imem_addr !== 32'd16) begin n_fail++; $display("FAIL full_addr: got %h expected 10", bus.imem_addr); end
        n_checks++; if (bus.instr_pc !== 32'd0 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL full_head: got pc %h v %b expected 0 1", bus.instr_pc, bus.instr_valid); end
        bus.instr_ready = 1;
        tick();
        bus.instr_ready = 0;
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL full_pop_req: got %b expected 1", bus.imem_req); end
        n_checks++; if (bus.imem_addr !== 32'd16) begin n_fail++; $display("FAIL full_pop_addr: got %h expected 10", bus.imem_addr); end
        n_checks++; if (bus.instr_pc !== 32'd4) begin n_fail++; $display("FAIL full_pop_head: got %h expected 4", bus.instr_pc); end
    endtask

    task automatic test_stall();
        int waited;
        do_reset();
        bus.fetch_en = 1; bus.imem_ack = 0;
        waited = 0;
        while (bus.imem_req !== 1'b1 && waited < 10) begin tick(); waited++; end
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_req_timeout: got %b expected 1", bus.imem_req); end
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL stall_hold c%0d: got req %b addr %h expected 1 %h", c, bus.imem_req, bus.imem_addr, RESET_PC); end
            tick();
        end
        bus.imem_ack = 1; bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack = 0;
        n_checks++; if (bus.imem_addr !== RESET_PC + 32'd4) begin n_fail++; $display("FAIL stall_advance: got %h expected %h", bus.imem_addr, RESET_PC + 32'd4); end
        n_checks++; if (bus.instruction !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_data: got %h expected deadbeef", bus.instruction); end
`ifdef IFU_STALL_COUNT_EN
        n_checks++; if (bus.stall_cycles !== 32'd3) begin n_fail++; $display("FAIL stall_count: got %0d expected 3", bus.stall_cycles); end
`endif
    endtask

    task automatic test_redirect();
        do_reset();
        bus.fetch_en = 1; bus.imem_ack = 1; bus.instr_ready = 0;
        repeat (3) begin bus.imem_rdata = $urandom; tick(); end
        n_checks++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL redir_pre: got v %b req %b expected 1 1", bus.instr_valid, bus.imem_req); end
        bus.redirect_valid = 1; bus.redirect_pc = 32'h0000_0103; bus.instr_ready = 1;
        bus.imem_rdata = 32'h1111_2222;
        tick();
        bus.redirect_valid = 0; bus.imem_ack = 0; bus.instr_ready = 0;
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b expected 0", bus.instr_valid); end
        n_checks++; if (bus.imem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_addr: got %h expected 00000100", bus.imem_addr); end
        n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL redir_req: got %b expected 1", bus.imem_req); end
        bus.imem_ack = 1; bus.imem_rdata = 32'hCAFE_0001;
        tick();
        bus.imem_ack = 0;
        n_checks++; if (bus.instr_pc !== 32'h0000_0100 || bus.instruction !== 32'hCAFE_0001) begin n_fail++; $display("FAIL redir_target: got %h/%h expected 00000100/cafe0001", bus.instr_pc, bus.instruction); end
    endtask

    task automatic test_reset_mid();
        int waited;
        do_reset();
        bus.fetch_en = 1; bus.imem_ack = 1; bus.instr_ready = 0;
        repeat (3) begin bus.imem_rdata = $urandom; tick(); end
        n_checks++; if (mq.size() !== 2 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got v %b expected 1 with 2 entries", bus.instr_valid); end
        reset = 1'b1;
        #1;
        n_checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL rmid_req: got %b %h expected 0 %h", bus.imem_req, bus.imem_addr, RESET_PC); end
        n_checks++; if (bus.instr_valid !== 1'b0 || bus.instruction !== 32'h0 || bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL rmid_out: got %b %h %h expected 0 0 0", bus.instr_valid, bus.instruction, bus.instr_pc); end
        @(posedge clk); #1;
        reset = 1'b0;
        mq.delete(); m_pc = RESET_PC; m_stall = 0;
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_ack_ignored: got %b expected 0", bus.instr_valid); end
        waited = 0;
        while (bus.imem_req !== 1'b1 && waited < 10) begin tick(); waited++; end
        n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL rmid_restart: got %b %h expected 1 %h", bus.imem_req, bus.imem_addr, RESET_PC); end
        bus.imem_rdata = 32'h5A5A_0000;
        tick();
        n_checks++; if (bus.instr_pc !== RESET_PC || bus.instruction !== 32'h5A5A_0000) begin n_fail++; $display("FAIL rmid_first: got %h/%h expected %h/5a5a0000", bus.instr_pc, bus.instruction, RESET_PC); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.fetch_en = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 0;
        n_checks++; if (bus.imem_addr !== 32'hFFFF_FFFC || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_pre: got %h req %b expected fffffffc 1", bus.imem_addr, bus.imem_req); end
        bus.imem_ack = 1; bus.imem_rdata = 32'h0BAD_F00D;
        tick();
        bus.imem_ack = 0;
        n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h expected 0", bus.imem_addr); end
        n_checks++; if (bus.instr_pc !== 32'hFFFF_FFFC || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_head: got %h v %b expected fffffffc 1", bus.instr_pc, bus.instr_valid); end
    endtask

    task automatic test_random();
        logic        p_req, p_ack, p_redir;
        logic [31:0] p_addr;
        do_reset();
        p_req = 0; p_ack = 0; p_redir = 0; p_addr = '0;
        for (int c = 0; c < 400; c++) begin
            n_checks++; if (bus.imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h expected %h", c, bus.imem_addr, m_pc); end
            n_checks++; if (bus.instr_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, bus.instr_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_checks++; if ({bus.instr_pc, bus.instruction} !== mq[0]) begin n_fail++; $display("FAIL rnd_head c%0d: got %h expected %h", c, {bus.instr_pc, bus.instruction}, mq[0]); end
            end
            if (mq.size() == DEPTH) begin
                n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rnd_full_req c%0d: got %b expected 0", c, bus.imem_req); end
            end
            if (p_req && !p_ack && !p_redir) begin
                n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== p_addr) begin n_fail++; $display("FAIL rnd_hold c%0d: got %b %h expected 1 %h", c, bus.imem_req, bus.imem_addr, p_addr); end
            end
`ifdef IFU_STALL_COUNT_EN
            n_checks++; if (bus.stall_cycles !== m_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %0d expected %0d", c, bus.stall_cycles, m_stall); end
`endif
            bus.fetch_en       = ($urandom_range(0, 9) != 0);
            bus.imem_ack       = $urandom_range(0, 1) != 0;
            bus.imem_rdata     = $urandom;
            bus.instr_ready    = ($urandom_range(0, 2) != 0);
            bus.redirect_valid = ($urandom_range(0, 19) == 0);
            bus.redirect_pc    = $urandom;
            p_req = bus.imem_req; p_ack = bus.imem_ack; p_redir = bus.redirect_valid; p_addr = bus.imem_addr;
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        m_pc = RESET_PC; m_stall = 0;
        test_reset();
        test_stream();
        test_full();
        test_stall();
        test_redirect();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
